// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out word serializer:
// FSM state encoding, default word width and bit-counter sizing.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable up-counter tracking which bit of the word is on the serial line.
// Reloads to 0, stops at WIDTH-1 and flags that value as terminal count.
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_count;

  assign o_tc = (r_count == CW'(WIDTH - 1));

  // Count register: reload wins over enable, and the count saturates at WIDTH-1.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a valid/ready word input, gapless
// back-to-back words and a hold input that freezes the serial stream.
// Optional even-parity bit after each word: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             hold,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_serial_out;
  logic             r_serial_valid;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             r_parity;
`endif

  logic             w_accept;
  logic             w_final;
  logic             w_tc;
  logic             w_cnt_en;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_rest;

  assign serial_out   = r_serial_out;
  assign serial_valid = r_serial_valid;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_accept),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  // Bit ordering: first bit of a new word and the next bit of the word in flight.
  always_comb begin
    // NOTE: every combinational output is assigned on every path so no latch is inferred.
    if (MSB_FIRST) begin
      w_load_bit   = data_in[WIDTH-1];
      w_load_rest  = {data_in[WIDTH-2:0], 1'b0};
      w_next_bit   = r_shift[WIDTH-1];
      w_shift_rest = {r_shift[WIDTH-2:0], 1'b0};
    end else begin
      w_load_bit   = data_in[0];
      w_load_rest  = {1'b0, data_in[WIDTH-1:1]};
      w_next_bit   = r_shift[0];
      w_shift_rest = {1'b0, r_shift[WIDTH-1:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; the slot ends on the last data bit or the parity bit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (!hold && w_tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = w_accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (!hold) w_next_state = w_accept ? SHIFT : IDLE;
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: ready in IDLE or in the final non-held cycle of a slot.
  always_comb begin
`ifdef PISO_SERIALIZER_PARITY_EN
    w_final = (r_state == PARITY);
`else
    w_final = (r_state == SHIFT) && w_tc;
`endif
    data_ready = (r_state == IDLE) || (w_final && !hold);
    w_accept   = data_valid && data_ready;
    w_cnt_en   = (r_state == SHIFT) && !hold;
    busy       = (r_state != IDLE);
  end

  // Serial datapath: load on accept, shift per non-held cycle, freeze on hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift        <= '0;
      r_serial_out   <= IDLE_LEVEL;
      r_serial_valid <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_parity       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shift        <= w_load_rest;
      r_serial_out   <= w_load_bit;
      r_serial_valid <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_parity       <= ^data_in;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (hold) begin
            r_serial_valid <= 1'b0;
          end else if (w_tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
            r_serial_out   <= r_parity;
            r_serial_valid <= 1'b1;
`else
            r_serial_out   <= IDLE_LEVEL;
            r_serial_valid <= 1'b0;
`endif
          end else begin
            r_shift        <= w_shift_rest;
            r_serial_out   <= w_next_bit;
            r_serial_valid <= 1'b1;
          end
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        PARITY: begin
          if (hold) begin
            r_serial_valid <= 1'b0;
          end else begin
            r_serial_out   <= IDLE_LEVEL;
            r_serial_valid <= 1'b0;
          end
        end
`endif
        default: begin
          r_serial_out   <= IDLE_LEVEL;
          r_serial_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first instance (idle level 0)
// and an LSB-first instance (idle level 1) share one stimulus stream and are
// compared every cycle against a slot/index reference model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int SLOT = W + 1;
`else
  localparam int SLOT = W;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         hold;
  logic [1:0]   w_ready, w_sout, w_svalid, w_busy;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(w_ready[0]), .hold(hold), .serial_out(w_sout[0]),
    .serial_valid(w_svalid[0]), .busy(w_busy[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(w_ready[1]), .hold(hold), .serial_out(w_sout[1]),
    .serial_valid(w_svalid[1]), .busy(w_busy[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0] tx_q[$];

  // Reference model: word in flight plus index of the slot position on the line.
  logic [W-1:0] m_word[2];
  int           m_idx[2];
  logic         m_active[2], m_out[2], m_valid[2];

  logic         obs_out[2], obs_valid[2], obs_ready[2], obs_busy[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic idle_of(input int k);
    return (k == 1);
  endfunction

  // Bit at slot position idx: data bits in line order, then the even parity bit.
  function automatic logic slot_bit(input int k, input logic [W-1:0] w, input int idx);
    if (idx >= W) return ^w;
    return (k == 0) ? w[W-1-idx] : w[idx];
  endfunction

  function automatic logic model_ready(input int k, input logic h);
    return !m_active[k] || ((m_idx[k] == SLOT - 1) && !h);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_word[k]   = '0;
      m_idx[k]    = 0;
      m_active[k] = 1'b0;
      m_out[k]    = idle_of(k);
      m_valid[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic h);
    for (int k = 0; k < 2; k++) begin
      if (v && model_ready(k, h)) begin
        m_word[k]   = d;
        m_idx[k]    = 0;
        m_active[k] = 1'b1;
        m_out[k]    = slot_bit(k, d, 0);
        m_valid[k]  = 1'b1;
      end else if (m_active[k]) begin
        if (h) begin
          m_valid[k] = 1'b0;
        end else if (m_idx[k] < SLOT - 1) begin
          m_idx[k]   = m_idx[k] + 1;
          m_out[k]   = slot_bit(k, m_word[k], m_idx[k]);
          m_valid[k] = 1'b1;
        end else begin
          m_active[k] = 1'b0;
          m_out[k]    = idle_of(k);
          m_valid[k]  = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive inputs just after a rising edge, compare on the falling
  // edge, advance the model on the next rising edge.
  task automatic one_cycle(input logic h, input logic gap);
    logic         v;
    logic [W-1:0] d;
    logic         acc;
    v = (tx_q.size() > 0) && !gap;
    if (v) d = tx_q[0];
    else   d = W'($urandom);
    data_valid = v;
    data_in    = d;
    hold       = h;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      obs_out[k]   = w_sout[k];
      obs_valid[k] = w_svalid[k];
      obs_ready[k] = w_ready[k];
      obs_busy[k]  = w_busy[k];
      check($sformatf("ready%0d", k), 32'(w_ready[k]), 32'(model_ready(k, h)));
      check($sformatf("sout%0d", k), 32'(w_sout[k]), 32'(m_out[k]));
      check($sformatf("svalid%0d", k), 32'(w_svalid[k]), 32'(m_valid[k]));
      check($sformatf("busy%0d", k), 32'(w_busy[k]), 32'(m_active[k]));
    end
    acc = v && model_ready(0, h);
    @(posedge clk);
    model_step(v, d, h);
    if (acc) void'(tx_q.pop_front());
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           run, maxrun, rdy_busy, n_rx, frozen, held, pos4, nvalid;
    logic [3:0]   last4;
    logic [W-1:0] rx;
    logic         h;

    reset_n    = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    hold       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_sout%0d", k), 32'(w_sout[k]), 32'(idle_of(k)));
      check($sformatf("rst_svalid%0d", k), 32'(w_svalid[k]), 32'd0);
      check($sformatf("rst_busy%0d", k), 32'(w_busy[k]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) one_cycle(1'b0, 1'b0);

    // Single word B0, MSB first: 1011 completes on the 4th serial bit.
    tx_q.push_back(8'hB0);
    n_rx = 0; rx = '0; last4 = '0; pos4 = 0;
    for (int i = 0; i < SLOT + 3; i++) begin
      one_cycle(1'b0, 1'b0);
      if (obs_valid[0] && n_rx < W) begin
        rx    = {rx[W-2:0], obs_out[0]};
        last4 = {last4[2:0], obs_out[0]};
        n_rx++;
        if (last4 == 4'b1011 && pos4 == 0) pos4 = n_rx;
      end
    end
    check("b0_stream", 32'(rx), 32'h000000B0);
    check("b0_detect_pos", 32'(pos4), 32'd4);

    // Back-to-back B0, 0B: gapless stream, ready pulses once per word.
    tx_q.push_back(8'hB0);
    tx_q.push_back(8'h0B);
    run = 0; maxrun = 0; rdy_busy = 0;
    for (int i = 0; i < 2 * SLOT + 4; i++) begin
      one_cycle(1'b0, 1'b0);
      if (obs_valid[0]) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      if (obs_ready[0] && obs_busy[0]) rdy_busy++;
    end
    check("b2b_run", 32'(maxrun), 32'(2 * SLOT));
    check("b2b_ready_pulses", 32'(rdy_busy), 32'd2);

    // Hold for 3 cycles while bit 4 of A5 is on the line.
    tx_q.push_back(8'hA5);
    n_rx = 0; rx = '0; frozen = 0; held = 0;
    for (int i = 0; i < SLOT + 8; i++) begin
      h = m_active[0] && (m_idx[0] == 4) && (held < 3);
      if (h) held++;
      one_cycle(h, 1'b0);
      if (obs_busy[0] && !obs_valid[0]) begin
        frozen++;
        check("hold_frozen_bit", 32'(obs_out[0]), 32'(slot_bit(0, 8'hA5, 4)));
      end
      if (obs_valid[0] && n_rx < W) begin
        rx = {rx[W-2:0], obs_out[0]};
        n_rx++;
      end
    end
    check("hold_frozen_cycles", 32'(frozen), 32'd3);
    check("hold_stream", 32'(rx), 32'h000000A5);

    // LSB-first instance with 01: a single 1 followed by seven 0s.
    tx_q.push_back(8'h01);
    n_rx = 0; rx = '0;
    for (int i = 0; i < SLOT + 3; i++) begin
      one_cycle(1'b0, 1'b0);
      if (obs_valid[1] && n_rx < W) begin
        rx[n_rx] = obs_out[1];
        n_rx++;
      end
    end
    check("lsb_stream", 32'(rx), 32'h00000001);
    check("lsb_count", 32'(n_rx), 32'(W));

`ifdef PISO_SERIALIZER_PARITY_EN
    // Parity of 07 is 1, sent in the 9th serial cycle with data_ready high.
    tx_q.push_back(8'h07);
    n_rx = 0;
    for (int i = 0; i < SLOT + 3; i++) begin
      one_cycle(1'b0, 1'b0);
      if (obs_valid[0]) begin
        n_rx++;
        if (n_rx == SLOT) begin
          check("parity_bit", 32'(obs_out[0]), 32'd1);
          check("parity_ready", 32'(obs_ready[0]), 32'd1);
        end
      end
    end
    check("parity_slot_len", 32'(n_rx), 32'(SLOT));
`endif

    // Reset asserted while bit 3 of C3 is on the line.
    tx_q.push_back(8'hC3);
    for (int i = 0; i < 20 && !(m_active[0] && m_idx[0] == 3); i++) one_cycle(1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("arst_svalid%0d", k), 32'(w_svalid[k]), 32'd0);
      check($sformatf("arst_sout%0d", k), 32'(w_sout[k]), 32'(idle_of(k)));
      check($sformatf("arst_busy%0d", k), 32'(w_busy[k]), 32'd0);
    end
    model_reset();
    tx_q.delete();
    data_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      one_cycle(1'b0, 1'b0);
      if (obs_valid[0] || obs_valid[1]) nvalid++;
    end
    check("post_reset_no_bits", 32'(nvalid), 32'd0);

    // Randomized traffic with upstream gaps, hold bursts and random data_in.
    for (int i = 0; i < 600; i++) begin
      if (tx_q.size() < 2 && ($urandom % 3) == 0) tx_q.push_back(W'($urandom));
      one_cycle(($urandom % 5) == 0, ($urandom % 6) == 0);
    end
    for (int i = 0; i < 4 * SLOT && (tx_q.size() > 0 || m_active[0]); i++) one_cycle(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
